cdb_wakeup_buffer: RTL and testbench

Receiving end of the Common Data Bus. A small operand-capture buffer for one functional unit:
- holds up to 2^DEPTH_BITS dispatched instructions whose source operands are tagged by ROB entry;
- snoops all four CDB lanes every cycle and captures matching data and exception flags;
- issues fully-ready entries to the functional unit over a valid/ready handshake.

It sits between dispatch and one FU, beside the other reservation stations.

---
 rtl/cdb_wakeup_buffer_pkg.sv | 12 +
 rtl/cdb_tag_match.sv | 31 +++
 rtl/cdb_wakeup_buffer.sv | 209 ++++++++++++++++++++
 tb/tb_cdb_wakeup_buffer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_wakeup_buffer_pkg.sv
// Shared constants for the CDB receive side: default geometry, the idle tag
// value and the number of broadcast lanes snooped every cycle.
package cdb_wakeup_buffer_pkg;

  localparam int DEPTH_BITS_DEF = 4;
  localparam int ROB_BITS_DEF   = 4;
  localparam int OP_WIDTH_DEF   = 12;
  localparam int DATA_W         = 32;
  localparam int CDB_LANES      = 4;
  localparam int NO_TAG         = 0;

endpackage

// File: rtl/cdb_tag_match.sv
// Compares one ROB tag against every CDB lane; the lowest-numbered matching
// lane supplies data and exception. Tag NO_TAG never matches.
module cdb_tag_match
  import cdb_wakeup_buffer_pkg::*;
#(
  parameter int TAG_W = ROB_BITS_DEF + 1
) (
  input  logic [TAG_W-1:0]                  tag_i,
  input  logic [CDB_LANES-1:0][TAG_W-1:0]   lane_tag_i,
  input  logic [CDB_LANES-1:0][DATA_W-1:0]  lane_data_i,
  input  logic [CDB_LANES-1:0]              lane_exc_i,
  output logic                              hit_o,
  output logic [DATA_W-1:0]                 data_o,
  output logic                              exc_o
);

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    exc_o  = 1'b0;
    // Walk from the top lane down so the lowest matching lane is written last.
    for (int l = CDB_LANES - 1; l >= 0; l--) begin
      if (tag_i != TAG_W'(NO_TAG) && lane_tag_i[l] == tag_i) begin
        hit_o  = 1'b1;
        data_o = lane_data_i[l];
        exc_o  = lane_exc_i[l];
      end
    end
  end

endmodule

// File: rtl/cdb_wakeup_buffer.sv
// Operand-capture buffer for one FU: holds dispatched entries, snoops the CDB
// and issues the lowest ready entry. `define CDB_ISSUE_BYPASS_EN for same-cycle wake-up.
module cdb_wakeup_buffer
  import cdb_wakeup_buffer_pkg::*;
#(
  parameter int DEPTH_BITS = DEPTH_BITS_DEF,
  parameter int ROB_BITS   = ROB_BITS_DEF,
  parameter int OP_WIDTH   = OP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  alloc_valid,
  output logic                  alloc_ready,
  input  logic [OP_WIDTH-1:0]   alloc_op,
  input  logic [ROB_BITS:0]     alloc_dest,
  input  logic [ROB_BITS:0]     alloc_Qj,
  input  logic [DATA_W-1:0]     alloc_Vj,
  input  logic [ROB_BITS:0]     alloc_Qk,
  input  logic [DATA_W-1:0]     alloc_Vk,
  input  logic [ROB_BITS:0]     cdb_ROBEN1,
  input  logic [ROB_BITS:0]     cdb_ROBEN2,
  input  logic [ROB_BITS:0]     cdb_ROBEN3,
  input  logic [ROB_BITS:0]     cdb_ROBEN4,
  input  logic [DATA_W-1:0]     cdb_Write_Data1,
  input  logic [DATA_W-1:0]     cdb_Write_Data2,
  input  logic [DATA_W-1:0]     cdb_Write_Data3,
  input  logic [DATA_W-1:0]     cdb_Write_Data4,
  input  logic                  cdb_EXCEPTION1,
  input  logic                  cdb_EXCEPTION2,
  input  logic                  cdb_EXCEPTION3,
  input  logic                  cdb_EXCEPTION4,
  output logic                  issue_valid,
  input  logic                  issue_ready,
  output logic [OP_WIDTH-1:0]   issue_op,
  output logic [ROB_BITS:0]     issue_dest,
  output logic [DATA_W-1:0]     issue_Vj,
  output logic [DATA_W-1:0]     issue_Vk,
  output logic                  issue_exception,
  output logic [DEPTH_BITS:0]   occupancy
);

  localparam int NUM   = 1 << DEPTH_BITS;
  localparam int TAG_W = ROB_BITS + 1;
  localparam int OCC_W = DEPTH_BITS + 1;
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(NO_TAG);

  typedef struct packed {
    logic                busy;
    logic [OP_WIDTH-1:0] op;
    logic [TAG_W-1:0]    dest;
    logic [TAG_W-1:0]    qj;
    logic [DATA_W-1:0]   vj;
    logic [TAG_W-1:0]    qk;
    logic [DATA_W-1:0]   vk;
    logic                exc;
  } entry_t;

  entry_t            ent_q [NUM];
  entry_t            ent_d [NUM];
  logic [OCC_W-1:0]  occ_q, occ_d;

  logic [CDB_LANES-1:0][TAG_W-1:0]  lane_tag;
  logic [CDB_LANES-1:0][DATA_W-1:0] lane_data;
  logic [CDB_LANES-1:0]             lane_exc;

  assign lane_tag  = {cdb_ROBEN4, cdb_ROBEN3, cdb_ROBEN2, cdb_ROBEN1};
  assign lane_data = {cdb_Write_Data4, cdb_Write_Data3, cdb_Write_Data2, cdb_Write_Data1};
  assign lane_exc  = {cdb_EXCEPTION4, cdb_EXCEPTION3, cdb_EXCEPTION2, cdb_EXCEPTION1};

  logic [NUM-1:0]    busy_vec, hit_j, hit_k, exc_j, exc_k, cand_rdy, cand_exc;
  logic [DATA_W-1:0] data_j [NUM];
  logic [DATA_W-1:0] data_k [NUM];
  logic [DATA_W-1:0] cand_vj [NUM];
  logic [DATA_W-1:0] cand_vk [NUM];

  for (genvar g = 0; g < NUM; g++) begin : g_ent
    cdb_tag_match #(.TAG_W(TAG_W)) u_match_j (
      .tag_i(ent_q[g].qj), .lane_tag_i(lane_tag), .lane_data_i(lane_data),
      .lane_exc_i(lane_exc), .hit_o(hit_j[g]), .data_o(data_j[g]), .exc_o(exc_j[g]));
    cdb_tag_match #(.TAG_W(TAG_W)) u_match_k (
      .tag_i(ent_q[g].qk), .lane_tag_i(lane_tag), .lane_data_i(lane_data),
      .lane_exc_i(lane_exc), .hit_o(hit_k[g]), .data_o(data_k[g]), .exc_o(exc_k[g]));

    assign busy_vec[g] = ent_q[g].busy;
`ifdef CDB_ISSUE_BYPASS_EN
    // Operands arriving this cycle count as present and are forwarded straight from the lane.
    assign cand_rdy[g] = ent_q[g].busy && (ent_q[g].qj == TAG_NONE || hit_j[g])
                                       && (ent_q[g].qk == TAG_NONE || hit_k[g]);
    assign cand_vj[g]  = hit_j[g] ? data_j[g] : ent_q[g].vj;
    assign cand_vk[g]  = hit_k[g] ? data_k[g] : ent_q[g].vk;
    assign cand_exc[g] = ent_q[g].exc | exc_j[g] | exc_k[g];
`else
    assign cand_rdy[g] = ent_q[g].busy && ent_q[g].qj == TAG_NONE && ent_q[g].qk == TAG_NONE;
    assign cand_vj[g]  = ent_q[g].vj;
    assign cand_vk[g]  = ent_q[g].vk;
    assign cand_exc[g] = ent_q[g].exc;
`endif
  end

  logic              a_hit_j, a_hit_k, a_exc_j, a_exc_k;
  logic [DATA_W-1:0] a_data_j, a_data_k;

  cdb_tag_match #(.TAG_W(TAG_W)) u_alloc_j (
    .tag_i(alloc_Qj), .lane_tag_i(lane_tag), .lane_data_i(lane_data),
    .lane_exc_i(lane_exc), .hit_o(a_hit_j), .data_o(a_data_j), .exc_o(a_exc_j));
  cdb_tag_match #(.TAG_W(TAG_W)) u_alloc_k (
    .tag_i(alloc_Qk), .lane_tag_i(lane_tag), .lane_data_i(lane_data),
    .lane_exc_i(lane_exc), .hit_o(a_hit_k), .data_o(a_data_k), .exc_o(a_exc_k));

  logic                  sel_found, free_found, alloc_fire, issue_fire;
  logic [DEPTH_BITS-1:0] sel_idx, free_idx;

  always_comb begin
    sel_found       = 1'b0;
    sel_idx         = '0;
    issue_valid     = 1'b0;
    issue_op        = '0;
    issue_dest      = '0;
    issue_Vj        = '0;
    issue_Vk        = '0;
    issue_exception = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if (!sel_found && cand_rdy[i]) begin
        sel_found       = 1'b1;
        sel_idx         = DEPTH_BITS'(i);
        issue_valid     = 1'b1;
        issue_op        = ent_q[i].op;
        issue_dest      = ent_q[i].dest;
        issue_Vj        = cand_vj[i];
        issue_Vk        = cand_vk[i];
        issue_exception = cand_exc[i];
      end
    end
  end

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!free_found && !busy_vec[i]) begin
        free_found = 1'b1;
        free_idx   = DEPTH_BITS'(i);
      end
    end
  end

  assign alloc_ready = ~&busy_vec;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_fire  = sel_found && issue_ready;
  assign occupancy   = occ_q;

  always_comb begin
    // NOTE: every next-state signal takes its hold value before any branch, so no latch can be inferred.
    for (int i = 0; i < NUM; i++) ent_d[i] = ent_q[i];
    occ_d = occ_q;

    for (int i = 0; i < NUM; i++) begin
      if (ent_q[i].busy && hit_j[i]) begin
        ent_d[i].qj  = TAG_NONE;
        ent_d[i].vj  = data_j[i];
        ent_d[i].exc = ent_d[i].exc | exc_j[i];
      end
      if (ent_q[i].busy && hit_k[i]) begin
        ent_d[i].qk  = TAG_NONE;
        ent_d[i].vk  = data_k[i];
        ent_d[i].exc = ent_d[i].exc | exc_k[i];
      end
    end

    if (issue_fire) ent_d[sel_idx].busy = 1'b0;

    if (alloc_fire) begin
      ent_d[free_idx] = '{busy: 1'b1, op: alloc_op, dest: alloc_dest,
                          qj: a_hit_j ? TAG_NONE : alloc_Qj,
                          vj: a_hit_j ? a_data_j : alloc_Vj,
                          qk: a_hit_k ? TAG_NONE : alloc_Qk,
                          vk: a_hit_k ? a_data_k : alloc_Vk,
                          exc: a_exc_j | a_exc_k};
    end

    case ({alloc_fire, issue_fire})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    if (flush) begin
      for (int i = 0; i < NUM; i++) begin
        ent_d[i].busy = 1'b0;
        ent_d[i].exc  = 1'b0;
      end
      occ_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: payload fields are reset along with busy so every field reads 0 out of reset.
      for (int i = 0; i < NUM; i++) ent_q[i] <= '0;
      occ_q <= '0;
    end else begin
      // NOTE: non-blocking updates make every register sample pre-edge values.
      for (int i = 0; i < NUM; i++) ent_q[i] <= ent_d[i];
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_cdb_wakeup_buffer.sv
// Randomised and directed bench for cdb_wakeup_buffer against an entry-list
// reference model that applies the buffer's rules cycle by cycle.
module tb_cdb_wakeup_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, alloc_valid, issue_ready;
  logic [11:0] alloc_op;
  logic [4:0]  alloc_dest, alloc_Qj, alloc_Qk;
  logic [31:0] alloc_Vj, alloc_Vk;
  logic [4:0]  c_tag  [4];
  logic [31:0] c_data [4];
  logic        c_exc  [4];

  logic        alloc_ready, issue_valid, issue_exception;
  logic [11:0] issue_op;
  logic [4:0]  issue_dest, occupancy;
  logic [31:0] issue_Vj, issue_Vk;

  cdb_wakeup_buffer dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_op(alloc_op),
    .alloc_dest(alloc_dest), .alloc_Qj(alloc_Qj), .alloc_Vj(alloc_Vj),
    .alloc_Qk(alloc_Qk), .alloc_Vk(alloc_Vk),
    .cdb_ROBEN1(c_tag[0]), .cdb_ROBEN2(c_tag[1]), .cdb_ROBEN3(c_tag[2]), .cdb_ROBEN4(c_tag[3]),
    .cdb_Write_Data1(c_data[0]), .cdb_Write_Data2(c_data[1]),
    .cdb_Write_Data3(c_data[2]), .cdb_Write_Data4(c_data[3]),
    .cdb_EXCEPTION1(c_exc[0]), .cdb_EXCEPTION2(c_exc[1]),
    .cdb_EXCEPTION3(c_exc[2]), .cdb_EXCEPTION4(c_exc[3]),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_dest(issue_dest), .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
    .issue_exception(issue_exception), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a plain list of 16 entries.
  bit          m_busy [16];
  logic [11:0] m_op   [16];
  logic [4:0]  m_dest [16], m_qj [16], m_qk [16];
  logic [31:0] m_vj   [16], m_vk [16];
  bit          m_exc  [16];

  bit          e_valid, e_exc, e_ready;
  logic [11:0] e_op;
  logic [4:0]  e_dest, e_occ;
  logic [31:0] e_vj, e_vk;
  int          e_sel;

  function automatic void lane_lookup(input logic [4:0] tag, output bit hit,
                                      output logic [31:0] d, output bit x);
    hit = 0; d = '0; x = 0;
    if (tag != 0)
      for (int l = 0; l < 4; l++)
        if (!hit && c_tag[l] == tag) begin
          hit = 1; d = c_data[l]; x = c_exc[l];
        end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = 0; m_op[i] = '0; m_dest[i] = '0; m_qj[i] = '0;
      m_qk[i] = '0; m_vj[i] = '0; m_vk[i] = '0; m_exc[i] = 0;
    end
  endfunction

  function automatic void model_outputs();
    int cnt = 0;
    bit rj, rk, x, h;
    logic [31:0] vj, vk, d;
    e_valid = 0; e_op = '0; e_dest = '0; e_vj = '0; e_vk = '0; e_exc = 0; e_sel = -1;
    for (int i = 0; i < 16; i++) if (m_busy[i]) cnt++;
    e_occ   = 5'(cnt);
    e_ready = (cnt < 16);
    for (int i = 0; i < 16; i++) begin
      if (m_busy[i] && e_sel < 0) begin
        rj = (m_qj[i] == 0); rk = (m_qk[i] == 0);
        vj = m_vj[i]; vk = m_vk[i]; x = m_exc[i];
`ifdef CDB_ISSUE_BYPASS_EN
        if (!rj) begin lane_lookup(m_qj[i], h, d, x); if (h) begin rj = 1; vj = d; end x = x | m_exc[i]; end
        if (!rk) begin bit xk; lane_lookup(m_qk[i], h, d, xk); if (h) begin rk = 1; vk = d; end x = x | xk; end
`endif
        if (rj && rk) begin
          e_sel = i; e_valid = 1; e_op = m_op[i]; e_dest = m_dest[i];
          e_vj = vj; e_vk = vk; e_exc = x;
        end
      end
    end
  endfunction

  function automatic void model_update();
    int tgt = -1;
    bit h, x;
    logic [31:0] d;
    if (flush) begin
      for (int i = 0; i < 16; i++) begin m_busy[i] = 0; m_exc[i] = 0; end
      return;
    end
    for (int i = 0; i < 16; i++) if (!m_busy[i] && tgt < 0) tgt = i;
    for (int i = 0; i < 16; i++) begin
      if (m_busy[i]) begin
        lane_lookup(m_qj[i], h, d, x);
        if (h) begin m_qj[i] = 0; m_vj[i] = d; m_exc[i] = m_exc[i] | x; end
        lane_lookup(m_qk[i], h, d, x);
        if (h) begin m_qk[i] = 0; m_vk[i] = d; m_exc[i] = m_exc[i] | x; end
      end
    end
    if (e_valid && issue_ready) m_busy[e_sel] = 0;
    if (alloc_valid && tgt >= 0) begin
      m_busy[tgt] = 1; m_op[tgt] = alloc_op; m_dest[tgt] = alloc_dest; m_exc[tgt] = 0;
      lane_lookup(alloc_Qj, h, d, x);
      m_qj[tgt] = h ? 5'd0 : alloc_Qj; m_vj[tgt] = h ? d : alloc_Vj; m_exc[tgt] = m_exc[tgt] | x;
      lane_lookup(alloc_Qk, h, d, x);
      m_qk[tgt] = h ? 5'd0 : alloc_Qk; m_vk[tgt] = h ? d : alloc_Vk; m_exc[tgt] = m_exc[tgt] | x;
    end
  endfunction

  task automatic settle();
    #3;
    model_outputs();
    check("alloc_ready", alloc_ready, e_ready);
    check("occupancy",   occupancy,   e_occ);
    check("issue_valid", issue_valid, e_valid);
    check("issue_op",    issue_op,    e_op);
    check("issue_dest",  issue_dest,  e_dest);
    check("issue_Vj",    issue_Vj,    e_vj);
    check("issue_Vk",    issue_Vk,    e_vk);
    check("issue_exc",   issue_exception, e_exc);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_valid = 0; alloc_op = '0; alloc_dest = '0;
    alloc_Qj = '0; alloc_Vj = '0; alloc_Qk = '0; alloc_Vk = '0;
    for (int l = 0; l < 4; l++) begin c_tag[l] = '0; c_data[l] = '0; c_exc[l] = 0; end
  endtask

  task automatic set_alloc(input logic [11:0] op, input logic [4:0] dest,
                           input logic [4:0] qj, input logic [31:0] vj,
                           input logic [4:0] qk, input logic [31:0] vk);
    alloc_valid = 1; alloc_op = op; alloc_dest = dest;
    alloc_Qj = qj; alloc_Vj = vj; alloc_Qk = qk; alloc_Vk = vk;
  endtask

  initial begin
    rst = 1; issue_ready = 0;
    idle_inputs();
    model_reset();
    #12 rst = 0;
    @(posedge clk); #1;

    // Reset state
    settle();
    check("rst_valid", issue_valid, 0);
    check("rst_ready", alloc_ready, 1);
    check("rst_occ",   occupancy,   0);
    advance();

    // 1: ready-on-dispatch entry issues next cycle
    issue_ready = 1;
    set_alloc(12'h001, 5'd3, 5'd0, 32'd5, 5'd0, 32'd7);
    tick();
    alloc_valid = 0;
    settle();
    check("t1_valid", issue_valid, 1);
    check("t1_vj",    issue_Vj,    5);
    check("t1_vk",    issue_Vk,    7);
    check("t1_dest",  issue_dest,  3);
    check("t1_occ1",  occupancy,   1);
    advance();
    settle();
    check("t1_occ0", occupancy, 0);
    advance();

    // 2: wake-up via CDB lane 2
    set_alloc(12'h002, 5'd4, 5'd6, 32'd0, 5'd0, 32'h77);
    tick();
    alloc_valid = 0;
    tick();
    c_tag[1] = 5'd6; c_data[1] = 32'hDEADBEEF;
    settle();
`ifdef CDB_ISSUE_BYPASS_EN
    check("t2_bypass_valid", issue_valid, 1);
    check("t2_bypass_vj",    issue_Vj,    32'hDEADBEEF);
`else
    check("t2_early_valid", issue_valid, 0);
`endif
    advance();
    idle_inputs();
    settle();
`ifndef CDB_ISSUE_BYPASS_EN
    check("t2_valid", issue_valid, 1);
    check("t2_vj",    issue_Vj,    32'hDEADBEEF);
`endif
    advance();

    // 3: alloc and broadcast of its tag in the same cycle, with exception
    set_alloc(12'h003, 5'd5, 5'd9, 32'd0, 5'd0, 32'd1);
    c_tag[3] = 5'd9; c_data[3] = 32'h42; c_exc[3] = 1;
    tick();
    idle_inputs();
    settle();
    check("t3_valid", issue_valid,     1);
    check("t3_vj",    issue_Vj,        32'h42);
    check("t3_exc",   issue_exception, 1);
    advance();

    // 4: fill all 16 entries waiting on tag 1
    issue_ready = 0;
    for (int i = 0; i < 16; i++) begin
      set_alloc(12'(16'h100 + i), 5'(i), 5'd1, 32'd0, 5'd0, 32'(i));
      tick();
    end
    set_alloc(12'hFFF, 5'd17, 5'd0, 32'd1, 5'd0, 32'd2);
    settle();
    check("t4_full_ready", alloc_ready, 0);
    check("t4_full_occ",   occupancy,   16);
    advance();
    idle_inputs();
    settle();
    check("t4_ignored_occ", occupancy, 16);
    advance();
    c_tag[0] = 5'd1; c_data[0] = 32'hCAFE0001;
    tick();
    idle_inputs();
    issue_ready = 1;
    for (int i = 0; i < 16; i++) begin
      settle();
      check("t4_order", issue_dest, 5'(i));
      advance();
    end

    // 5: two lanes carry the same tag; lane 1 wins
    issue_ready = 0;
    set_alloc(12'h005, 5'd7, 5'd5, 32'd0, 5'd0, 32'd3);
    tick();
    idle_inputs();
    c_tag[0] = 5'd5; c_data[0] = 32'h11;
    c_tag[2] = 5'd5; c_data[2] = 32'h33;
    tick();
    idle_inputs();
    settle();
    check("t5_vj", issue_Vj, 32'h11);
    advance();
    issue_ready = 1;
    tick();

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      flush       = ($urandom_range(0, 49) == 0);
      alloc_valid = ($urandom_range(0, 9) < 6);
      issue_ready = ($urandom_range(0, 9) < 6);
      alloc_op    = 12'($urandom);
      alloc_dest  = 5'($urandom);
      alloc_Qj    = ($urandom_range(0, 9) < 4) ? 5'd0 : 5'($urandom_range(1, 7));
      alloc_Qk    = ($urandom_range(0, 9) < 4) ? 5'd0 : 5'($urandom_range(1, 7));
      alloc_Vj    = $urandom;
      alloc_Vk    = $urandom;
      for (int l = 0; l < 4; l++) begin
        c_tag[l]  = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
        c_data[l] = $urandom;
        c_exc[l]  = ($urandom_range(0, 7) == 0);
      end
      tick();
    end

    // 6: flush with concurrent alloc and issue, then asynchronous reset
    idle_inputs();
    issue_ready = 0;
    flush = 1;
    tick();
    flush = 0;
    for (int i = 0; i < 8; i++) begin
      set_alloc(12'(i), 5'(i + 8), 5'd0, 32'(i), 5'd0, 32'(i));
      tick();
    end
    idle_inputs();
    settle();
    check("t6_occ8", occupancy, 8);
    advance();
    flush = 1; issue_ready = 1;
    set_alloc(12'hABC, 5'd2, 5'd0, 32'd9, 5'd0, 32'd9);
    tick();
    idle_inputs();
    issue_ready = 0;
    settle();
    check("t6_flush_occ",   occupancy,   0);
    check("t6_flush_valid", issue_valid, 0);
    advance();
    for (int i = 0; i < 2; i++) begin
      set_alloc(12'h0F0, 5'd1, 5'd0, 32'h55, 5'd0, 32'h66);
      tick();
    end
    idle_inputs();
    settle();
    check("t6_pre_rst_valid", issue_valid, 1);
    #1 rst = 1;
    #1;
    check("t6_rst_valid", issue_valid, 0);
    check("t6_rst_vj",    issue_Vj,    0);
    check("t6_rst_dest",  issue_dest,  0);
    check("t6_rst_occ",   occupancy,   0);
    check("t6_rst_ready", alloc_ready, 1);
    model_reset();
    model_outputs();
    #2 rst = 0;
    advance();
    settle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
